// File: rtl/vram_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_if : video-fetch and CPU-access bus bundle for vram_responder         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vram_if #(
    parameter int AW    = 13,
    parameter int CNT_W = 16
);
    logic [AW-1:0]    vram_address;
    logic [7:0]       vram_data;
    logic             cpu_req;
    logic             cpu_we;
    logic [AW-1:0]    cpu_addr;
    logic [7:0]       cpu_wdata;
    logic [7:0]       cpu_rdata;
    logic             cpu_ack;
    logic             cpu_wait;
    logic [CNT_W-1:0] contention;

    modport master (
        output vram_address, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vram_data, cpu_rdata, cpu_ack, cpu_wait, contention
    );

    modport slave (
        input  vram_address, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vram_data, cpu_rdata, cpu_ack, cpu_wait, contention
    );
endinterface
`default_nettype wire

// File: rtl/vram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_responder : single-port screen RAM shared by video fetch and the CPU  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vram_responder #(
    parameter int DEPTH = 6912,
    parameter int AW    = 13,
    parameter int CNT_W = 16
) (
    input  wire logic clk_pix,
    input  wire logic reset,
    vram_if.slave     bus
);
    localparam logic [AW:0] c_depth = DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_last_vid_addr;
    logic             r_vid_valid;
    logic             r_vid_dirty;
    logic             r_ack;
    logic [7:0]       r_vram_data;
    logic [7:0]       r_cpu_rdata;
    logic [CNT_W-1:0] r_contention;

    state_t           w_state;
    logic             w_vid_in_range;
    logic             w_cpu_in_range;
    logic             w_cpu_write;

    assign w_vid_in_range = ({1'b0, bus.vram_address} < c_depth);
    assign w_cpu_in_range = ({1'b0, bus.cpu_addr} < c_depth);

    // The access slot is re-arbitrated every cycle; nothing carries over but the
    // video bookkeeping and the ack register.
    always_comb begin
        w_state = ST_IDLE;
        if ((bus.vram_address != r_last_vid_addr) || !r_vid_valid || r_vid_dirty) begin
            w_state = ST_VID;
        end else if (bus.cpu_req && !r_ack) begin
            w_state = ST_CPU;
        end
    end

    assign w_cpu_write = (w_state == ST_CPU) && bus.cpu_we && !reset;

    // RAM contents survive reset, so the array has its own reset-free process.
    always_ff @(posedge clk_pix) begin
        if (w_cpu_write && w_cpu_in_range) begin
            r_mem[bus.cpu_addr] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            r_last_vid_addr <= '0;
            r_vid_valid     <= 1'b0;
            r_vid_dirty     <= 1'b0;
            r_ack           <= 1'b0;
            r_vram_data     <= 8'h00;
            r_cpu_rdata     <= 8'h00;
            r_contention    <= '0;
        end else begin
            r_ack <= 1'b0;
            case (w_state)
                ST_VID: begin
                    r_vram_data     <= w_vid_in_range ? r_mem[bus.vram_address] : 8'hFF;
                    r_last_vid_addr <= bus.vram_address;
                    r_vid_valid     <= 1'b1;
                    r_vid_dirty     <= 1'b0;
                end
                ST_CPU: begin
                    r_ack <= 1'b1;
                    if (!bus.cpu_we) begin
                        r_cpu_rdata <= w_cpu_in_range ? r_mem[bus.cpu_addr] : 8'hFF;
                    end else if (bus.cpu_addr == r_last_vid_addr) begin
                        r_vid_dirty <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (bus.cpu_req && !r_ack && (w_state == ST_VID) && (r_contention != '1)) begin
                r_contention <= r_contention + 1'b1;
            end
        end
    end

    assign bus.vram_data  = r_vram_data;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ack    = r_ack;
    assign bus.cpu_wait   = bus.cpu_req & ~r_ack;
    assign bus.contention = r_contention;
endmodule
`default_nettype wire

// File: tb/tb_vram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for vram_responder: directed scenarios plus a randomized run checked
// against a transaction-level memory/latency model.
module tb_vram_responder;
    logic clk_pix = 1'b0;
    logic reset   = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] mdl [0:8191];

    vram_if bus ();

    vram_responder dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #5_000_000;
        $display("FAIL watchdog elapsed=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic logic [7:0] expv(input logic [12:0] a);
        if (a >= 13'd6912) return 8'hFF;
        return mdl[a];
    endfunction

    function automatic logic [12:0] pick_idx(input int i);
        if (i < 64) return 13'(32'h100 + i);
        return 13'(32'h1AF0 + i - 64);
    endfunction

    task automatic do_reset();
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    // Full CPU transaction with bounded wait for the ack.
    task automatic cpu_op(input logic we, input logic [12:0] a, input logic [7:0] wd,
                          output logic [7:0] rd);
        int n;
        n = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        do begin
            tick();
            n++;
        end while (!bus.cpu_ack && n < 20);
        checks++;
        if (bus.cpu_ack !== 1'b1) begin
            failures++;
            $display("FAIL cpu_op_ack addr=%h ack=%b required=1", a, bus.cpu_ack);
        end
        rd = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.vram_address = 13'h0000;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.vram_data !== 8'h00 || bus.cpu_rdata !== 8'h00 || bus.cpu_ack !== 1'b0 ||
            bus.contention !== 16'h0000 || bus.cpu_wait !== 1'b0) begin
            failures++;
            $display("FAIL reset_values vdata=%h rdata=%h ack=%b cnt=%h wait=%b required=00/00/0/0000/0",
                     bus.vram_data, bus.cpu_rdata, bus.cpu_ack, bus.contention, bus.cpu_wait);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_video();
        logic [7:0] rd;
        cpu_op(1'b1, 13'h0000, 8'h3C, rd);
        cpu_op(1'b1, 13'h1800, 8'h47, rd);
        bus.vram_address = 13'h0000;
        tick();
        tick();
        checks++;
        if (bus.vram_data !== 8'h3C) begin
            failures++;
            $display("FAIL video_0000 got=%h required=3c", bus.vram_data);
        end
        bus.vram_address = 13'h1800;
        tick();
        checks++;
        if (bus.vram_data !== 8'h47) begin
            failures++;
            $display("FAIL video_1800_latency got=%h required=47", bus.vram_data);
        end
        tick();
        checks++;
        if (bus.vram_data !== 8'h47) begin
            failures++;
            $display("FAIL video_hold got=%h required=47", bus.vram_data);
        end
    endtask

    task automatic test_cpu_rw();
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0123; bus.cpu_wdata = 8'hA5;
        #1;
        checks++;
        if (bus.cpu_wait !== 1'b1) begin
            failures++;
            $display("FAIL wr_wait got=%b required=1", bus.cpu_wait);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_wait !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack ack=%b wait=%b required=1/0", bus.cpu_ack, bus.cpu_wait);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_pulse got=%b required=0", bus.cpu_ack);
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hA5) begin
            failures++;
            $display("FAIL rd_data ack=%b rdata=%h required=1/a5", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.contention !== 16'd0) begin
            failures++;
            $display("FAIL rw_contention ack=%b cnt=%0d required=0/0", bus.cpu_ack, bus.contention);
        end
    endtask

    task automatic test_contention();
        bus.vram_address = 13'h0000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0000;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.cpu_wait !== 1'b1) begin
            failures++;
            $display("FAIL cont_stall ack=%b wait=%b required=0/1", bus.cpu_ack, bus.cpu_wait);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h3C || bus.contention !== 16'd1) begin
            failures++;
            $display("FAIL cont_served ack=%b rdata=%h cnt=%0d required=1/3c/1",
                     bus.cpu_ack, bus.cpu_rdata, bus.contention);
        end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_dirty();
        logic [7:0] rd;
        cpu_op(1'b1, 13'h1AFF, 8'h00, rd);
        bus.vram_address = 13'h1AFF;
        tick();
        tick();
        checks++;
        if (bus.vram_data !== 8'h00) begin
            failures++;
            $display("FAIL dirty_pre got=%h required=00", bus.vram_data);
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1AFF; bus.cpu_wdata = 8'h7E;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.vram_data !== 8'h00) begin
            failures++;
            $display("FAIL dirty_cpu_edge ack=%b vdata=%h required=1/00", bus.cpu_ack, bus.vram_data);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.vram_data !== 8'h7E) begin
            failures++;
            $display("FAIL dirty_refresh got=%h required=7e", bus.vram_data);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd;
        cpu_op(1'b1, 13'h1B00, 8'h12, rd);
        cpu_op(1'b0, 13'h1B00, 8'h00, rd);
        checks++;
        if (rd !== 8'hFF) begin
            failures++;
            $display("FAIL oor_read got=%h required=ff", rd);
        end
        bus.vram_address = 13'h1FFF;
        tick();
        tick();
        checks++;
        if (bus.vram_data !== 8'hFF) begin
            failures++;
            $display("FAIL oor_video got=%h required=ff", bus.vram_data);
        end
    endtask

    task automatic test_random();
        logic [7:0]  rd;
        logic [12:0] a;
        logic [12:0] op_a;
        logic [7:0]  op_d;
        logic        op_we, busy, in_ack, ackseen;
        int          t, start, hold, stall, exp_cnt;
        for (int i = 0; i < 96; i++) begin
            a = pick_idx(i);
            if (a < 13'd6912) begin
                mdl[a] = 8'($urandom);
                cpu_op(1'b1, a, mdl[a], rd);
            end
        end
        bus.vram_address = pick_idx($urandom_range(0, 95));
        do_reset();
        exp_cnt = 0; t = 0; start = 0; hold = 3; busy = 1'b0; in_ack = 1'b0;
        op_we = 1'b0; op_a = '0; op_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            t++;
            ackseen = bus.cpu_ack;
            if (ackseen) begin
                checks++;
                if (!busy) begin
                    failures++;
                    $display("FAIL rnd_spurious_ack t=%0d ack=1 required=0", t);
                end else begin
                    stall = t - start - 1 - (in_ack ? 1 : 0);
                    checks++;
                    if (stall < 0 || stall > 2) begin
                        failures++;
                        $display("FAIL rnd_stall_bound stall=%0d required=0..2", stall);
                    end
                    exp_cnt += stall;
                    checks++;
                    if (bus.contention !== 16'(exp_cnt)) begin
                        failures++;
                        $display("FAIL rnd_contention got=%0d required=%0d", bus.contention, exp_cnt);
                    end
                    if (!op_we) begin
                        checks++;
                        if (bus.cpu_rdata !== expv(op_a)) begin
                            failures++;
                            $display("FAIL rnd_read addr=%h got=%h required=%h",
                                     op_a, bus.cpu_rdata, expv(op_a));
                        end
                    end else if (op_a < 13'd6912) begin
                        mdl[op_a] = op_d;
                    end
                    busy = 1'b0;
                end
            end else if (busy && (t - start) > 20) begin
                checks++;
                failures++;
                $display("FAIL rnd_ack_timeout addr=%h ack=0 required=1", op_a);
                busy = 1'b0;
            end
            // The display byte trails a write to its own address by one cycle.
            if (!(ackseen && op_we && op_a == bus.vram_address)) begin
                checks++;
                if (bus.vram_data !== expv(bus.vram_address)) begin
                    failures++;
                    $display("FAIL rnd_video addr=%h got=%h required=%h",
                             bus.vram_address, bus.vram_data, expv(bus.vram_address));
                end
            end
            if (hold == 0) begin
                bus.vram_address = pick_idx($urandom_range(0, 95));
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            if (!busy && $urandom_range(0, 2) == 0) begin
                busy   = 1'b1;
                start  = t;
                in_ack = ackseen;
                op_we  = 1'($urandom_range(0, 1));
                op_a   = ($urandom_range(0, 3) == 0) ? bus.vram_address
                                                     : pick_idx($urandom_range(0, 95));
                op_d   = 8'($urandom);
                bus.cpu_req = 1'b1; bus.cpu_we = op_we; bus.cpu_addr = op_a; bus.cpu_wdata = op_d;
            end else if (!busy) begin
                bus.cpu_req = 1'b0;
            end
            #1;
            checks++;
            if (bus.cpu_wait !== (bus.cpu_req & ~ackseen)) begin
                failures++;
                $display("FAIL rnd_wait got=%b required=%b", bus.cpu_wait, bus.cpu_req & ~ackseen);
            end
        end
        bus.cpu_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        bus.vram_address = bus.vram_address ^ 13'h0001;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0100;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL inflight_stall ack=%b required=0", bus.cpu_ack);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.vram_data !== 8'h00 || bus.cpu_rdata !== 8'h00 ||
            bus.contention !== 16'd0) begin
            failures++;
            $display("FAIL inflight_reset ack=%b vdata=%h rdata=%h cnt=%0d required=0/00/00/0",
                     bus.cpu_ack, bus.vram_data, bus.cpu_rdata, bus.contention);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.contention !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_vid ack=%b cnt=%0d required=0/1", bus.cpu_ack, bus.contention);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== expv(13'h0100)) begin
            failures++;
            $display("FAIL post_reset_served ack=%b rdata=%h required=1/%h",
                     bus.cpu_ack, bus.cpu_rdata, expv(13'h0100));
        end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0100;
        for (int i = 1; i <= 65545; i++) begin
            bus.vram_address = bus.vram_address ^ 13'h0001;
            tick();
            checks++;
            if (bus.cpu_ack !== 1'b0) begin
                failures++;
                $display("FAIL sat_no_ack i=%0d ack=%b required=0", i, bus.cpu_ack);
            end
            if (i == 65534) begin
                checks++;
                if (bus.contention !== 16'hFFFE) begin
                    failures++;
                    $display("FAIL sat_pre got=%h required=fffe", bus.contention);
                end
            end
            if (i == 65535 || i == 65545) begin
                checks++;
                if (bus.contention !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL sat_hold i=%0d got=%h required=ffff", i, bus.contention);
                end
            end
        end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_video();
        test_cpu_rw();
        test_contention();
        test_dirty();
        test_out_of_range();
        test_random();
        test_reset_inflight();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
